// File: rtl/dp_blram.sv
// rtl/dp_blram.sv - true dual-port byte-writable block RAM with optional output register
module dp_blram #(
  parameter int SIZE    = 14,
  parameter int DEPTH   = 2**14,
  parameter int DW      = 32,
  parameter int NB      = DW/8,
  parameter int OUT_REG = 0,
  parameter int RD_MODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en_a,
  input  logic            i_en_b,
  input  logic [NB-1:0]   i_we_a,
  input  logic [NB-1:0]   i_we_b,
  input  logic [SIZE-1:0] i_addr_a,
  input  logic [SIZE-1:0] i_addr_b,
  input  logic [DW-1:0]   i_data_a,
  input  logic [DW-1:0]   i_data_b,
  output logic [DW-1:0]   o_data_a,
  output logic [DW-1:0]   o_data_b,
  output logic            o_valid_a,
  output logic            o_valid_b
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] memory [0:DEPTH-1];

  logic          in_a, in_b;
  logic [AW-1:0] idx_a, idx_b;
  logic [DW-1:0] rd_a, rd_b;
  logic          v1_a, v1_b;
  logic [DW-1:0] d1_a, d1_b;

  // Out-of-range addresses neither write nor read; only the low bits index the array.
  assign in_a  = 32'(i_addr_a) < 32'(DEPTH);
  assign in_b  = 32'(i_addr_b) < 32'(DEPTH);
  assign idx_a = i_addr_a[AW-1:0];
  assign idx_b = i_addr_b[AW-1:0];

  // Overlay the enabled byte lanes of new_w onto old_w.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = old_w;
    for (int k = 0; k < NB; k++) begin
      if (we[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

  // Read word per port: write-first sees only its own port's write merged over the old word;
  // the other port's same-cycle write is never visible (memory is read before update).
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_a) rd_a = (RD_MODE != 0) ? merge(memory[idx_a], i_data_a, i_we_a) : memory[idx_a];
    if (in_b) rd_b = (RD_MODE != 0) ? merge(memory[idx_b], i_data_b, i_we_b) : memory[idx_b];
  end

  // Byte-lane writes; port A is applied last so it wins any lane both ports write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (i_en_b && in_b) begin
        for (int k = 0; k < NB; k++) begin
          if (i_we_b[k]) memory[idx_b][8*k +: 8] <= i_data_b[8*k +: 8];
        end
      end
      if (i_en_a && in_a) begin
        for (int k = 0; k < NB; k++) begin
          if (i_we_a[k]) memory[idx_a][8*k +: 8] <= i_data_a[8*k +: 8];
        end
      end
    end
  end

  // First read stage: capture the read word and its valid; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      d1_a <= '0;
      d1_b <= '0;
    end else begin
      v1_a <= i_en_a;
      v1_b <= i_en_b;
      if (i_en_a) d1_a <= rd_a;
      if (i_en_b) d1_b <= rd_b;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic          v2_a, v2_b;
      logic [DW-1:0] d2_a, d2_b;

      // Optional output register stage adding one cycle of latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          v2_a <= 1'b0;
          v2_b <= 1'b0;
          d2_a <= '0;
          d2_b <= '0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) d2_a <= d1_a;
          if (v1_b) d2_b <= d1_b;
        end
      end

      assign o_valid_a = v2_a;
      assign o_valid_b = v2_b;
      assign o_data_a  = d2_a;
      assign o_data_b  = d2_b;
    end else begin : g_no_out_reg
      assign o_valid_a = v1_a;
      assign o_valid_b = v1_b;
      assign o_data_a  = d1_a;
      assign o_data_b  = d1_b;
    end
  endgenerate

endmodule
